// File: rtl/tsv_link_pkg.sv
// Shared definitions for the inter-layer TSV token link: token layout, receiver
// states and error-cause codes.
package tsv_link_pkg;

  localparam logic [15:0] MARKER_DEF = 16'hBEAF;
  localparam logic [1:0]  HDR        = 2'b11;
  localparam int          WORD_W     = 32;

  // Token layout: {HDR, p_state, src_id, dst_id, MARKER}
  localparam int HDR_MSB = 31;
  localparam int HDR_LSB = 30;
  localparam int PST_MSB = 29;
  localparam int PST_LSB = 26;
  localparam int SRC_MSB = 25;
  localparam int SRC_LSB = 21;
  localparam int DST_MSB = 20;
  localparam int DST_LSB = 16;
  localparam int MRK_MSB = 15;
  localparam int MRK_LSB = 0;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_HDR  = 2'd0,
    ERR_PAR  = 2'd1,
    ERR_STOP = 2'd2,
    ERR_TMO  = 2'd3
  } err_t;

  // Destination of a valid token is always the next ID, wrapping in 5 bits.
  function automatic logic [4:0] next_id(input logic [4:0] id);
    return id + 5'd1;
  endfunction

endpackage

// File: rtl/tsv_frame_check.sv
// Combinational validation of a received token plus its parity and stop bits.
// Parity is enforced only when TSV_PARITY_CHECK_EN is defined.
module tsv_frame_check
  import tsv_link_pkg::*;
#(
  parameter logic [15:0] MARKER = MARKER_DEF
) (
  input  logic [WORD_W-1:0] word,
  input  logic              par_bit,
  input  logic              stop_bit,
  output logic              good,
  output err_t              err_type
);

  logic hdr_ok;
  logic mrk_ok;
  logic id_ok;
  logic par_ok;
  logic stop_ok;

  assign hdr_ok  = (word[HDR_MSB:HDR_LSB] == HDR);
  assign mrk_ok  = (word[MRK_MSB:MRK_LSB] == MARKER);
  assign id_ok   = (word[DST_MSB:DST_LSB] == next_id(word[SRC_MSB:SRC_LSB]));
  assign stop_ok = ~stop_bit;

`ifdef TSV_PARITY_CHECK_EN
  // Even parity across the 32 data bits and the parity bit itself.
  assign par_ok = ~(^word ^ par_bit);
`else
  logic unused_par;
  assign unused_par = par_bit;
  assign par_ok     = 1'b1;
`endif

  always_comb begin
    good     = stop_ok & par_ok & hdr_ok & mrk_ok & id_ok;
    err_type = ERR_HDR;
    if (!stop_ok) begin
      err_type = ERR_STOP;
    end else if (!par_ok) begin
      err_type = ERR_PAR;
    end
  end

endmodule

// File: rtl/tsv_frame_rx.sv
// Serial receiver for the TSV ID-assignment token; presents only validated words.
// Define TSV_PARITY_CHECK_EN to reject frames with bad even parity.
module tsv_frame_rx
  import tsv_link_pkg::*;
#(
  parameter logic [15:0] MARKER  = MARKER_DEF,
  parameter int          TIMEOUT = 40,
  parameter int          ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rx_en,
  input  logic              rx_bit,
  output logic [WORD_W-1:0] data_word,
  output logic              word_valid,
  output logic [3:0]        p_state_o,
  output logic [4:0]        src_id,
  output logic [4:0]        dst_id,
  output logic              frame_err,
  output logic [1:0]        err_type,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t            state_reg;
  logic [WORD_W-1:0] shift_reg;
  logic [4:0]        bit_cnt_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              par_reg;

  logic             chk_good;
  err_t             chk_err;
  logic             timeout_hit;
  logic [ERR_W-1:0] err_cnt_next;

  // The stop bit is judged straight off the line on the edge that samples it.
  tsv_frame_check #(
    .MARKER (MARKER)
  ) u_check (
    .word     (shift_reg),
    .par_bit  (par_reg),
    .stop_bit (rx_bit),
    .good     (chk_good),
    .err_type (chk_err)
  );

  assign timeout_hit  = (state_reg != HUNT) && !rx_en &&
                        (to_cnt_reg == TO_W'(TIMEOUT - 1));
  assign err_cnt_next = (&err_cnt) ? err_cnt : err_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= HUNT;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      par_reg     <= 1'b0;
      data_word   <= '0;
      word_valid  <= 1'b0;
      frame_err   <= 1'b0;
      err_type    <= '0;
      err_cnt     <= '0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (clr) begin
        state_reg   <= HUNT;
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
        to_cnt_reg  <= '0;
        par_reg     <= 1'b0;
        data_word   <= '0;
        err_type    <= '0;
        err_cnt     <= '0;
      end else if (state_reg != HUNT && !rx_en) begin
        if (timeout_hit) begin
          state_reg   <= HUNT;
          bit_cnt_reg <= '0;
          to_cnt_reg  <= '0;
          frame_err   <= 1'b1;
          err_type    <= ERR_TMO;
          err_cnt     <= err_cnt_next;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end else if (rx_en) begin
        to_cnt_reg <= '0;
        case (state_reg)
          HUNT: begin
            if (rx_bit) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            shift_reg   <= {shift_reg[WORD_W-2:0], rx_bit};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 5'd31) begin
              state_reg <= PAR;
            end
          end
          PAR: begin
            par_reg   <= rx_bit;
            state_reg <= STOP;
          end
          STOP: begin
            // A stop bit of 1 is an error, never a fresh start bit.
            state_reg <= HUNT;
            if (chk_good) begin
              data_word  <= shift_reg;
              word_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_type  <= chk_err;
              err_cnt   <= err_cnt_next;
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

  assign p_state_o = data_word[PST_MSB:PST_LSB];
  assign src_id    = data_word[SRC_MSB:SRC_LSB];
  assign dst_id    = data_word[DST_MSB:DST_LSB];
  assign busy      = (state_reg != HUNT);

endmodule

// File: tb/tb_tsv_frame_rx.sv
// Directed plus randomized bench for tsv_frame_rx against a frame-level reference
// model; honours TSV_PARITY_CHECK_EN the same way as the design.
module tb_tsv_frame_rx;

  localparam logic [15:0] MK = 16'hBEAF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        rx_en = 1'b0;
  logic        rx_bit = 1'b0;
  logic [31:0] data_word;
  logic        word_valid;
  logic [3:0]  p_state_o;
  logic [4:0]  src_id;
  logic [4:0]  dst_id;
  logic        frame_err;
  logic [1:0]  err_type;
  logic [7:0]  err_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] exp_word = '0;
  int          exp_cnt  = 0;
  logic [1:0]  exp_type = '0;

  tsv_frame_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .rx_en      (rx_en),
    .rx_bit     (rx_bit),
    .data_word  (data_word),
    .word_valid (word_valid),
    .p_state_o  (p_state_o),
    .src_id     (src_id),
    .dst_id     (dst_id),
    .frame_err  (frame_err),
    .err_type   (err_type),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick(input logic en, input logic b);
    rx_en  = en;
    rx_bit = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tok(input logic [3:0] p, input logic [4:0] s,
                                      input logic [4:0] d, input logic [15:0] m);
    return {2'b11, p, s, d, m};
  endfunction

  function automatic logic even_par(input logic [31:0] w);
    return ($countones(w) % 2) == 1;
  endfunction

  // -1 = accept, otherwise the expected error code.
  function automatic int verdict(input logic [31:0] w, input logic par, input logic stop);
    if (stop) return 2;
`ifdef TSV_PARITY_CHECK_EN
    if ((($countones(w) + int'(par)) % 2) != 0) return 1;
`endif
    if (w[31:30] != 2'b11) return 0;
    if (w[15:0] != MK) return 0;
    if (int'(w[20:16]) != ((int'(w[25:21]) + 1) % 32)) return 0;
    return -1;
  endfunction

  function automatic int bump(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  task automatic check_outputs(input string tag, input logic wv, input logic fe);
    chk({tag, ".word_valid"}, 32'(word_valid), 32'(wv));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
    chk({tag, ".data_word"}, data_word, exp_word);
    chk({tag, ".err_type"}, 32'(err_type), 32'(exp_type));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".fields"}, {15'd0, p_state_o, src_id, dst_id},
        {15'd0, exp_word[29:26], exp_word[25:21], exp_word[20:16]});
  endtask

  // Sends start, 32 data bits MSB first, parity, stop. Optional random gaps
  // before each bit, an optional fixed stall before bit index stall_at, and
  // optional clr coincident with the stop bit.
  task automatic send_frame(input string tag, input logic [31:0] w, input logic par,
                            input logic stop, input int gap_max, input bit clr_at_stop,
                            input int stall_at, input int stall_len);
    logic bits [35];
    int   g;
    int   v;
    logic wv;
    logic fe;
    bits[0] = 1'b1;
    for (int i = 0; i < 32; i++) bits[1 + i] = w[31 - i];
    bits[33] = par;
    bits[34] = stop;
    for (int i = 0; i < 35; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (i > 0) repeat (g) tick(1'b0, 1'b0);
      if (i == stall_at) repeat (stall_len) tick(1'b0, 1'b0);
      if (i == 34 && clr_at_stop) clr = 1'b1;
      tick(1'b1, bits[i]);
      clr = 1'b0;
    end
    v  = verdict(w, par, stop);
    wv = 1'b0;
    fe = 1'b0;
    if (clr_at_stop) begin
      exp_word = '0;
      exp_cnt  = 0;
      exp_type = '0;
    end else if (v < 0) begin
      exp_word = w;
      wv       = 1'b1;
    end else begin
      fe       = 1'b1;
      exp_type = 2'(v);
      exp_cnt  = bump(exp_cnt);
    end
    $display("%s: frame %08h par=%0d stop=%0d clr=%0d -> %s", tag, w, par, stop,
             clr_at_stop, clr_at_stop ? "flushed" : (v < 0 ? "accept" : "reject"));
    check_outputs(tag, wv, fe);
  endtask

  task automatic idle_check(input string tag);
    tick(1'b0, 1'b0);
    chk({tag, ".wv_clear"}, 32'(word_valid), 32'd0);
    chk({tag, ".fe_clear"}, 32'(frame_err), 32'd0);
  endtask

  task automatic random_frame(input string tag, input int kind, input int gap_max);
    logic [3:0]  p;
    logic [4:0]  s;
    logic [4:0]  d;
    logic [15:0] m;
    logic [31:0] w;
    logic        par;
    logic        stop;
    p    = 4'($urandom);
    s    = 5'($urandom);
    d    = 5'((int'(s) + 1) % 32);
    m    = MK;
    stop = 1'b0;
    if (kind == 1) m = MK ^ 16'($urandom_range(16'hFFFF, 1));
    if (kind == 2) d = 5'((int'(s) + int'($urandom_range(31, 2))) % 32);
    w = tok(p, s, d, m);
    if (kind == 3) w[31:30] = 2'($urandom_range(2, 0));
    par = even_par(w);
    if (kind == 4) par = ~par;
    if (kind == 5) stop = 1'b1;
    send_frame(tag, w, par, stop, gap_max, 1'b0, -1, 0);
  endtask

  initial begin
    logic [31:0] w;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    check_outputs("reset", 1'b0, 1'b0);

    // Reference good token and field decode
    send_frame("good", 32'hC422BEAF, 1'b1, 1'b0, 0, 1'b0, -1, 0);
    chk("good.src", 32'(src_id), 32'd1);
    chk("good.dst", 32'(dst_id), 32'd2);
    chk("good.pst", 32'(p_state_o), 32'd1);
    idle_check("good");

    send_frame("marker", tok(4'd1, 5'd1, 5'd2, 16'hBEEF), even_par(tok(4'd1, 5'd1, 5'd2, 16'hBEEF)),
               1'b0, 0, 1'b0, -1, 0);
    idle_check("marker");

    w = tok(4'd3, 5'd3, 5'd5, MK);
    send_frame("id_plus2", w, even_par(w), 1'b0, 1, 1'b0, -1, 0);
    w = tok(4'd7, 5'd31, 5'd0, MK);
    send_frame("id_wrap", w, even_par(w), 1'b0, 1, 1'b0, -1, 0);
    idle_check("id_wrap");

    send_frame("par_flip", 32'hC422BEAF, 1'b0, 1'b0, 0, 1'b0, -1, 0);
    idle_check("par_flip");

    // Stop=1 followed immediately by a frame: stop must not act as a start bit
    w = tok(4'd2, 5'd9, 5'd10, MK);
    send_frame("stop_err", w, even_par(w), 1'b1, 0, 1'b0, -1, 0);
    w = tok(4'd4, 5'd12, 5'd13, MK);
    send_frame("b2b_a", w, even_par(w), 1'b0, 0, 1'b0, -1, 0);
    w = tok(4'd5, 5'd20, 5'd21, MK);
    send_frame("b2b_b", w, even_par(w), 1'b0, 0, 1'b0, -1, 0);
    idle_check("b2b");

    // 39 idle cycles after data bit 10 is tolerated
    w = tok(4'd6, 5'd2, 5'd3, MK);
    send_frame("stall39", w, even_par(w), 1'b0, 0, 1'b0, 12, 39);
    idle_check("stall39");

    // 40 idle cycles after data bit 10 aborts
    w = tok(4'd8, 5'd4, 5'd5, MK);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 11; i++) tick(1'b1, w[31 - i]);
    repeat (39) tick(1'b0, 1'b0);
    chk("tmo.busy_before", 32'(busy), 32'd1);
    chk("tmo.fe_before", 32'(frame_err), 32'd0);
    tick(1'b0, 1'b0);
    exp_type = 2'd3;
    exp_cnt  = bump(exp_cnt);
    $display("timeout: frame %08h aborted after data bit 10", w);
    check_outputs("tmo", 1'b0, 1'b1);
    idle_check("tmo");
    send_frame("after_tmo", w, even_par(w), 1'b0, 0, 1'b0, -1, 0);
    idle_check("after_tmo");

    for (int n = 0; n < 40; n++) random_frame("rand", int'($urandom_range(5, 0)), 3);
    idle_check("rand");

    // Asynchronous reset mid-frame
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom));
    rx_en = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    exp_word = '0;
    exp_cnt  = 0;
    exp_type = '0;
    tick(1'b0, 1'b0);
    $display("async_reset: partial frame dropped");
    check_outputs("arst", 1'b0, 1'b0);
    send_frame("after_arst", 32'hC422BEAF, 1'b1, 1'b0, 0, 1'b0, -1, 0);

    // Saturation, then clr coincident with a good frame's stop bit
    for (int n = 0; n < 300; n++) begin
      int k;
      k = int'($urandom_range(3, 0));
      random_frame("sat", (k == 0) ? 5 : k, 0);
    end
    chk("sat.err_cnt", 32'(err_cnt), 32'd255);
    send_frame("clr_stop", 32'hC422BEAF, 1'b1, 1'b0, 0, 1'b1, -1, 0);
    idle_check("clr_stop");
    chk("clr.data_word", data_word, 32'd0);
    chk("clr.err_cnt", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
